// File: rtl/aes_pkg.sv
// Shared AES SubBytes definitions: FSM states, byte-position helpers and S-box tables.
// The inverse table is only consumed when AES_INV_SBOX_EN is defined.
package aes_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } state_t;

  // Index 0 sits in the most significant byte, so SBOX[b] is S(b).
  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  localparam logic [0:255][7:0] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb,
    128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e,
    128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692,
    128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506,
    128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673,
    128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b,
    128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f,
    128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961,
    128'h172b047eba77d626e169146355210c7d
  };

  function automatic logic [7:0] sbox_fwd(input logic [7:0] b);
    return SBOX[b];
  endfunction

  function automatic logic [7:0] sbox_inv(input logic [7:0] b);
    return INV_SBOX[b];
  endfunction

  // Column-major state: byte k holds row k mod 4, column k div 4.
  function automatic logic [1:0] row_of(input logic [3:0] k);
    return k[1:0];
  endfunction

  function automatic logic [1:0] col_of(input logic [3:0] k);
    return k[3:2];
  endfunction

  // Destination of source byte k after ShiftRows (inv=0) or InvShiftRows (inv=1).
  function automatic logic [3:0] shift_pos(input logic [3:0] k, input logic inv);
    logic [1:0] r;
    logic [1:0] c;
    logic [1:0] c_new;
    r = row_of(k);
    c = col_of(k);
    c_new = inv ? (c + r) : (c - r);
    return {c_new, r};
  endfunction

endpackage

// File: rtl/aes_sbox_rom.sv
// One S-box lane: synchronous ROM with a registered output, read only while en is high.
// The inverse table and the inv select exist only when AES_INV_SBOX_EN is defined.
module aes_sbox_rom
  import aes_pkg::*;
(
  input  logic       clk,
  input  logic       en,
  input  logic       inv,
  input  logic [7:0] addr,
  output logic [7:0] data
);

`ifdef AES_INV_SBOX_EN
  always_ff @(posedge clk) begin
    if (en) data <= inv ? sbox_inv(addr) : sbox_fwd(addr);
  end
`else
  logic unused_inv;
  assign unused_inv = inv;

  always_ff @(posedge clk) begin
    if (en) data <= sbox_fwd(addr);
  end
`endif

endmodule

// File: rtl/aes_subbytes_seq.sv
// Multi-lane sequential AES (Inv)SubBytes with optional fused (Inv)ShiftRows.
// Define AES_INV_SBOX_EN to build the inverse tables and honour mode_in.
module aes_subbytes_seq
  import aes_pkg::*;
#(
  parameter int LANES          = 1,
  parameter bit FUSE_SHIFTROWS = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         mode_in,
  input  logic [127:0] data_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] data_out,
  output logic         busy
);

  localparam int BEATS  = 16 / LANES;
  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

  generate
    if (LANES != 1 && LANES != 2 && LANES != 4 && LANES != 8 && LANES != 16) begin : g_bad_lanes
      $error("aes_subbytes_seq: LANES must be 1, 2, 4, 8 or 16");
    end
  endgenerate

  state_t            state;
  state_t            state_nxt;
  logic [BEAT_W-1:0] beat;
  logic              last_beat;
  logic              accept;
  logic              issue;
  logic              mode_reg;
  logic [0:15][7:0]  src_reg;
  logic [0:15][7:0]  dst_reg;
  logic              wr_vld_p1;
  logic [BEAT_W-1:0] wr_beat_p1;
  logic [7:0]        rom_data [LANES];
  logic [3:0]        dst_idx  [LANES];

  assign last_beat = (beat == BEAT_W'(BEATS - 1));
  assign accept    = in_valid && in_ready;
  assign issue     = (state == ISSUE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    unique case (state)
      IDLE: begin
        in_ready = rst;
        if (in_valid && rst) state_nxt = ISSUE;
      end
      ISSUE: begin
        busy = 1'b1;
        if (last_beat) state_nxt = CAPTURE;
      end
      CAPTURE: begin
        busy      = 1'b1;
        state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                   beat <= '0;
    else if (accept)            beat <= '0;
    else if (issue && last_beat) beat <= '0;
    else if (issue)             beat <= beat + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (accept) src_reg <= data_in;
  end

`ifdef AES_INV_SBOX_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)        mode_reg <= 1'b0;
    else if (accept) mode_reg <= mode_in;
  end
`else
  logic unused_mode;
  assign unused_mode = mode_in;
  assign mode_reg    = 1'b0;
`endif

  // Stage p0 -> p1: address issued this beat, ROM data lands for the next cycle's write
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) wr_vld_p1 <= 1'b0;
    else      wr_vld_p1 <= issue;
  end

  always_ff @(posedge clk) begin
    wr_beat_p1 <= beat;
  end

  for (genvar j = 0; j < LANES; j++) begin : g_lane
    logic [3:0] src_idx_p0;
    logic [3:0] src_idx_p1;

    assign src_idx_p0 = 4'(int'(beat) * LANES + j);
    assign src_idx_p1 = 4'(int'(wr_beat_p1) * LANES + j);
    assign dst_idx[j] = FUSE_SHIFTROWS ? shift_pos(src_idx_p1, mode_reg) : src_idx_p1;

    aes_sbox_rom u_rom (
      .clk  (clk),
      .en   (issue),
      .inv  (mode_reg),
      .addr (src_reg[src_idx_p0]),
      .data (rom_data[j])
    );
  end

  // Stage p1: scatter each lane's substituted byte to its (shifted) position
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dst_reg <= '0;
    end else if (wr_vld_p1) begin
      for (int j = 0; j < LANES; j++) dst_reg[dst_idx[j]] <= rom_data[j];
    end
  end

  assign data_out = dst_reg;

endmodule

// File: tb/tb_aes_subbytes_seq.sv
// Directed bench: three configurations (1 lane fused, 4 lanes unfused, 16 lanes fused) share stimulus.
module tb_aes_subbytes_seq;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         in_valid = 1'b0;
  logic         mode_in = 1'b0;
  logic         out_ready = 1'b0;
  logic [127:0] data_in = '0;

  logic         rdy1, ov1, bz1;
  logic         rdy4, ov4, bz4;
  logic         rdy16, ov16, bz16;
  logic [127:0] do1, do4, do16;

  int checks = 0;
  int failures = 0;

  localparam logic [127:0] V_ZERO  = 128'h0;
  localparam logic [127:0] V_SUB63 = {16{8'h63}};
  localparam logic [127:0] V_PT    = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] V_SR    = 128'h63fcac161bee28c3c4c193f54b8233ea;
  localparam logic [127:0] V_SB    = 128'h638293c31bfc33f5c4eeacea4bc12816;

  always #5 clk = ~clk;

  aes_subbytes_seq #(.LANES(1), .FUSE_SHIFTROWS(1'b1)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy1), .mode_in(mode_in),
    .data_in(data_in), .out_valid(ov1), .out_ready(out_ready), .data_out(do1), .busy(bz1)
  );

  aes_subbytes_seq #(.LANES(4), .FUSE_SHIFTROWS(1'b0)) u_dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy4), .mode_in(mode_in),
    .data_in(data_in), .out_valid(ov4), .out_ready(out_ready), .data_out(do4), .busy(bz4)
  );

  aes_subbytes_seq #(.LANES(16), .FUSE_SHIFTROWS(1'b1)) u_dut16 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy16), .mode_in(mode_in),
    .data_in(data_in), .out_valid(ov16), .out_ready(out_ready), .data_out(do16), .busy(bz16)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Accept one state on all DUTs, hold out_ready low until every result is up,
  // optionally keep backpressure for `hold` cycles, then release.
  task automatic run_op(input string tag, input logic [127:0] din, input logic md,
                        input logic [127:0] exp_f, input logic [127:0] exp_n,
                        input bit chk_n, input int hold);
    int lat1  = -1;
    int lat4  = -1;
    int lat16 = -1;
    chk({tag, ".idle_rdy"}, 128'({rdy1, rdy4, rdy16}), 128'(3'b111));
    data_in  = din;
    mode_in  = md;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    mode_in  = ~md;
    data_in  = '1;
    chk({tag, ".busy"}, 128'({bz1, rdy1, bz4, rdy4}), 128'(4'b1010));
    for (int k = 1; k <= 40 && (lat1 < 0 || lat4 < 0 || lat16 < 0); k++) begin
      @(negedge clk);
      if (ov1 && lat1 < 0) lat1 = k;
      if (ov4 && lat4 < 0) lat4 = k;
      if (ov16 && lat16 < 0) lat16 = k;
    end
    chk({tag, ".lat1"}, 128'(lat1), 128'(17));
    chk({tag, ".lat4"}, 128'(lat4), 128'(5));
    chk({tag, ".lat16"}, 128'(lat16), 128'(2));
    chk({tag, ".data1"}, do1, exp_f);
    chk({tag, ".data16"}, do16, exp_f);
    if (chk_n) chk({tag, ".data4"}, do4, exp_n);
    for (int h = 0; h < hold; h++) begin
      if (h == 3) begin
        data_in  = V_PT;
        in_valid = 1'b1;
      end
      if (h == 4) in_valid = 1'b0;
      @(negedge clk);
      chk({tag, ".hold_ctl"}, 128'({ov1, rdy1, bz1, ov4, rdy4}), 128'(5'b10010));
      chk({tag, ".hold_data"}, do1, exp_f);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, ".release"}, 128'({ov1, rdy1, ov4, rdy4, ov16, rdy16}), 128'(6'b010101));
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("reset.ctl", 128'({rdy1, ov1, bz1, rdy16, ov16, bz16}), 128'(6'b000000));
    chk("reset.data", do1, V_ZERO);
    rst = 1'b1;
    @(negedge clk);
    chk("post_reset.rdy", 128'({rdy1, rdy4, rdy16}), 128'(3'b111));

    run_op("zero", V_ZERO, 1'b0, V_SUB63, V_SUB63, 1'b1, 0);
    run_op("vec", V_PT, 1'b0, V_SR, V_SB, 1'b1, 0);
`ifdef AES_INV_SBOX_EN
    run_op("inv", V_SR, 1'b1, V_PT, V_ZERO, 1'b0, 0);
`else
    run_op("mode_ign", V_PT, 1'b1, V_SR, V_SB, 1'b1, 0);
`endif
    run_op("bp", V_PT, 1'b0, V_SR, V_SB, 1'b1, 10);

    // Reset while the single-lane DUT is issuing beat 2.
    data_in  = V_PT;
    mode_in  = 1'b0;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("midrst.busy_before", 128'({bz1, bz4}), 128'(2'b11));
    rst = 1'b0;
    #1;
    chk("midrst.ctl", 128'({ov1, bz1, ov4, bz4, ov16, bz16}), 128'(6'b000000));
    chk("midrst.data1", do1, V_ZERO);
    chk("midrst.data16", do16, V_ZERO);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    run_op("after_rst", V_ZERO, 1'b0, V_SUB63, V_SUB63, 1'b1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
